// File: rtl/mips_store_pkg.sv
// Shared types and helpers for the MIPS store-merge path.
package mips_store_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = 4;

  typedef enum logic [2:0] {
    ST_SW  = 3'b000,
    ST_SH  = 3'b001,
    ST_SB  = 3'b010,
    ST_SWL = 3'b011,
    ST_SWR = 3'b100
  } store_type_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    RDWAIT,
    WRITE
  } state_t;

  // Captured store payload: lane-aligned data plus its byte-lane mask
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [LANES-1:0]  mask;
  } store_cap_t;

  // Expand a 4-bit lane mask into a 32-bit bit mask
  function automatic logic [DATA_W-1:0] expand_mask(input logic [LANES-1:0] m);
    logic [DATA_W-1:0] bits;
    bits = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      bits[8*i +: 8] = {8{m[i]}};
    end
    return bits;
  endfunction

endpackage

// File: rtl/store_lane_align.sv
// Combinational lane alignment for MIPS stores: aligned data, byte mask and
// an error flag for misaligned SW/SH or an unknown store type.
module store_lane_align
  import mips_store_pkg::*;
(
  input  logic [2:0]        store_type,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] aligned_c,
  output logic [LANES-1:0]  mask_c,
  output logic              misalign_c
);

  logic [1:0] inv_lo;
  logic [4:0] sh_l;
  logic [4:0] sh_r;

  assign inv_lo = 2'd3 - addr_lo;
  assign sh_l   = {addr_lo, 3'b000};
  assign sh_r   = {inv_lo, 3'b000};

  always_comb begin
    aligned_c  = '0;
    mask_c     = '0;
    misalign_c = 1'b0;
    case (store_type)
      ST_SW: begin
        aligned_c  = wdata;
        mask_c     = 4'b1111;
        misalign_c = (addr_lo != 2'b00);
      end
      ST_SH: begin
        aligned_c  = DATA_W'(wdata[15:0]) << sh_l;
        mask_c     = 4'b0011 << addr_lo;
        misalign_c = addr_lo[0];
      end
      ST_SB: begin
        aligned_c = DATA_W'(wdata[7:0]) << sh_l;
        mask_c    = 4'b0001 << addr_lo;
      end
      // SWL fills the low lanes 0..k with the top bytes of rt
      ST_SWL: begin
        aligned_c = wdata >> sh_r;
        mask_c    = 4'b1111 >> inv_lo;
      end
      ST_SWR: begin
        aligned_c = wdata << sh_l;
        mask_c    = 4'b1111 << addr_lo;
      end
      default: misalign_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_merge_unit.sv
// Store data path: aligns store data, does read-modify-write on word-only
// memories, and writes the result over a waitrequest-style bus.
module store_merge_unit
  import mips_store_pkg::*;
#(
  parameter bit HAS_BYTEENABLE = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        store_type,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              done,
  output logic              err,
  output logic [31:0]       mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [LANES-1:0]  mem_byteenable,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_waitrequest
);

  state_t            state_q, state_d;
  store_cap_t        cap_q, cap_d;
  logic              ready_d, done_d, err_d, rd_d, wr_d;
  logic [31:0]       addr_d;
  logic [DATA_W-1:0] wdat_d;
  logic [LANES-1:0]  be_d;

  logic [DATA_W-1:0] aligned_c;
  logic [LANES-1:0]  mask_c;
  logic              misalign_c;
  logic [DATA_W-1:0] mask_bits_c;
  logic [DATA_W-1:0] merged_c;

  store_lane_align u_align (
    .store_type (store_type),
    .addr_lo    (addr[1:0]),
    .wdata      (wdata),
    .aligned_c  (aligned_c),
    .mask_c     (mask_c),
    .misalign_c (misalign_c)
  );

  assign mask_bits_c = expand_mask(cap_q.mask);
  assign merged_c    = (cap_q.data & mask_bits_c) | (mem_readdata & ~mask_bits_c);

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cap_q          <= '0;
      req_ready      <= 1'b1;
      done           <= 1'b0;
      err            <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_writedata  <= '0;
      mem_byteenable <= 4'b1111;
    end else begin
      state_q        <= state_d;
      cap_q          <= cap_d;
      req_ready      <= ready_d;
      done           <= done_d;
      err            <= err_d;
      mem_read       <= rd_d;
      mem_write      <= wr_d;
      mem_address    <= addr_d;
      mem_writedata  <= wdat_d;
      mem_byteenable <= be_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rd_d    = mem_read;
    wr_d    = mem_write;
    addr_d  = mem_address;
    wdat_d  = mem_writedata;
    be_d    = mem_byteenable;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (misalign_c) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            cap_d.data = aligned_c;
            cap_d.mask = mask_c;
            addr_d     = {addr[31:2], 2'b00};
            if (HAS_BYTEENABLE || (mask_c == 4'b1111)) begin
              state_d = WRITE;
              wr_d    = 1'b1;
              wdat_d  = aligned_c & expand_mask(mask_c);
              be_d    = HAS_BYTEENABLE ? mask_c : 4'b1111;
            end else begin
              state_d = READ;
              rd_d    = 1'b1;
              be_d    = 4'b1111;
            end
          end
        end
      end
      READ: begin
        if (!mem_waitrequest) begin
          rd_d    = 1'b0;
          state_d = RDWAIT;
        end
      end
      // Read data is valid exactly one cycle after the read was accepted
      RDWAIT: begin
        wdat_d  = merged_c;
        wr_d    = 1'b1;
        state_d = WRITE;
      end
      WRITE: begin
        if (!mem_waitrequest) begin
          wr_d    = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

endmodule

// File: doc/store_merge_unit.md
# store_merge_unit

Store-side counterpart of the load extraction path in the MIPS data-memory stage. It takes a store request (SW, SH, SB, SWL, SWR) with a byte address and register data, and aligns the data into the correct byte lanes. For partial stores on a word-only memory it performs a read-modify-write sequence; it then writes the merged word over a waitrequest-style memory bus and reports completion or misalignment to the CPU.

## Interface
- HAS_BYTEENABLE, 0: 1 means memory honours mem_byteenable, so partial stores skip the read phase; 0 means byteenable is always 4'b1111 and partial stores use read-modify-write.
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  store request present
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid & req_ready
- store_type  in  3  store type: 000 SW, 001 SH, 010 SB, 011 SWL, 100 SWR; others invalid
- addr  in  32  byte address
- wdata  in  32  rt register value
- done  out  1  one-cycle completion pulse
- err  out  1  qualifies done: misaligned or invalid request, no memory access made
- mem_address  out  32  word address, {addr[31:2],2'b00}
- mem_read  out  1  read strobe
- mem_write  out  1  write strobe
- mem_byteenable  out  4  lane mask when HAS_BYTEENABLE=1, else 4'b1111
- mem_writedata  out  32  merged/aligned word
- mem_readdata  in  32  valid exactly one cycle after read accept
- mem_waitrequest  in  1  holds the current read/write; a strobe is accepted in a cycle where it is high and waitrequest is low

## Operation
- Little-endian lanes: byte k occupies bits [8k+7:8k], with k = addr[1:0].
- Alignment and mask, with k = addr[1:0]:
  - SW: data = wdata, mask 1111; requires k==0.
  - SH: data = wdata[15:0] placed at lane k, mask 0011<<k; requires k[0]==0.
  - SB: data = wdata[7:0] placed at lane k, mask 0001<<k.
  - SWL: data = wdata >> 8*(3-k), mask = lanes 0..k.
  - SWR: data = wdata << 8*k, mask = lanes k..3.
- Error path: misaligned SW/SH or an invalid store_type goes straight to done+err. There is no memory access.
- Merge: merged = (aligned & mask_bits) | (readdata & ~mask_bits).
- FSM states are IDLE, READ, RDWAIT, WRITE.
  - IDLE: on accept, register type, address, aligned data and mask. Go to WRITE if the mask is full or HAS_BYTEENABLE=1; go to READ if the mask is partial and HAS_BYTEENABLE=0; stay in IDLE and pulse done+err next cycle on an error.
  - READ: hold mem_read until accepted, then go to RDWAIT.
  - RDWAIT: capture mem_readdata, form the merged word, go to WRITE.
  - WRITE: hold mem_write, mem_writedata and mem_byteenable stable until accepted, then go to IDLE with done=1 on the next cycle.
- All outputs are registered. mem_address, mem_writedata and mem_byteenable are stable while their strobe is asserted.
- Request inputs are ignored outside IDLE. req_valid does not have to be held after accept.

## Timing
- Reset values: state IDLE, req_ready=1, done=0, err=0, mem_read=0, mem_write=0, mem_address=0, mem_writedata=0, mem_byteenable=4'b1111.
- Latency with zero wait is counted from the accept edge (cycle 0):
  - Full write: mem_write in cycle 1, done in cycle 2.
  - Read-modify-write: mem_read in cycle 1, capture in cycle 2, mem_write in cycle 3, done in cycle 4.
  - Error: done+err in cycle 1.
- Each waitrequest cycle adds one cycle.
- done coincides with req_ready=1, so back-to-back accept in the done cycle is legal.
- Reset mid-operation: at the next edge the block returns to IDLE and drops mem_read/mem_write. No done is issued, and the in-flight store is lost.
- mem_readdata is sampled only in RDWAIT.

## Structure
- Package mips_store_pkg holds:
  - the store_type_t enum (SW/SH/SB/SWL/SWR codes above);
  - the state_t enum;
  - the lane-mask expansion function (4-bit mask to 32-bit bit mask).
- Sub-module store_lane_align is purely combinational. It takes store_type, addr[1:0] and wdata, and produces aligned data, the 4-bit mask and a misalign flag. It is instantiated once, on the request inputs.
- The top level holds the FSM, the capture registers and the merge logic.

## Test plan
- SB, addr 0x1003, wdata 0x000000AB, memory word 0x11223344, HAS_BYTEENABLE=0 → read at 0x1000, then write 0xAB223344, done in cycle 4, err=0.
- SH, addr 0x1002, wdata 0x0000BEEF, memory 0x11223344 → write 0xBEEF3344.
- SWL and SWR, wdata 0xAABBCCDD, addr 0x2001, memory 0x11223344 → SWL writes 0x1122AABB; SWR writes 0xBBCCDD44.
- SW, addr 0x3000, wdata 0xDEADBEEF, waitrequest held 3 cycles → no read; mem_write and data stay stable 4 cycles; done on the cycle after release.
- SH addr 0x1001, and store_type 3'b111 → no mem strobes; done=err=1 in cycle 1; a new request is accepted on the same cycle.
- Reset asserted while in READ → mem_read=0 and req_ready=1 next cycle; no done pulse.
